// File: rtl/aes128_inv_cipher_iter_if.sv
// aes128_inv_cipher_iter_if: ciphertext in, plaintext out and round-key lookup bus.
// master drives ciphertext, round keys and sink readiness; slave is the decryptor.
interface aes128_inv_cipher_iter_if;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [127:0] data_in, data_out, rk;
   logic [3:0]   rk_idx;
   modport master (output in_valid, data_in, out_ready, rk, input in_ready, out_valid, data_out, rk_idx);
   modport slave (input in_valid, data_in, out_ready, rk, output in_ready, out_valid, data_out, rk_idx);
endinterface

// File: rtl/aes128_inv_cipher_iter.sv
// aes128_inv_cipher_iter: iterative AES-128 inverse cipher, one inverse round per clock.
// Optional synchronous abort input enabled by AES128_INV_CIPHER_ABORT_EN.
module aes128_inv_cipher_iter #(
   parameter int NR = 10
) (
   input logic clk,
   input logic rst,
`ifdef AES128_INV_CIPHER_ABORT_EN
   input logic abort,
`endif
   aes128_inv_cipher_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
   // byte b of the inverse S-box sits at bits [2047-8b -: 8]
   localparam logic [2047:0] inv_sbox_tbl = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return inv_sbox_tbl[11'd2047 - {b, 3'b000} -: 8];
   endfunction
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4], x2 [4], x4 [4], x8 [4], me [4], mb [4], md [4], m9 [4];
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2[i] = xt(a[i]);
         x4[i] = xt(x2[i]);
         x8[i] = xt(x4[i]);
         me[i] = x8[i] ^ x4[i] ^ x2[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         m9[i] = x8[i] ^ a[i];
      end
      for (int i = 0; i < 4; i++)
         res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
      return res;
   endfunction
   fsm_t         fsm, fsm_d;
   logic [127:0] st, st_d, sub, add, mix;
   logic [3:0]   cnt, cnt_d;
   logic         abt;
`ifdef AES128_INV_CIPHER_ABORT_EN
   assign abt = abort;
`else
   assign abt = 1'b0;
`endif
   // InvShiftRows folded into the S-box input selection: row r rotates right by r
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sub[127-32*c-8*r -: 8] = inv_sbox(st[127-32*((c+4-r)%4)-8*r -: 8]);
      end
      assign mix[127-32*c -: 32] = inv_mix_col(add[127-32*c -: 32]);
   end
   assign add = sub ^ bus.rk;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fsm <= IDLE;
         st  <= '0;
         cnt <= '0;
      end else begin
         fsm <= fsm_d;
         st  <= st_d;
         cnt <= cnt_d;
      end
   always_comb begin
      fsm_d         = fsm;
      st_d          = st;
      cnt_d         = cnt;
      bus.in_ready  = fsm == IDLE;
      bus.out_valid = fsm == DONE;
      bus.rk_idx    = fsm == ROUND ? cnt : 4'(NR);
      bus.data_out  = st;
      case (fsm)
         IDLE: if (bus.in_valid && !abt) begin
            fsm_d = ROUND;
            st_d  = bus.data_in ^ bus.rk;
            cnt_d = 4'(NR - 1);
         end
         ROUND: begin
            st_d  = cnt == 4'd0 ? add : mix;
            cnt_d = cnt == 4'd0 ? cnt : cnt - 4'd1;
            fsm_d = cnt == 4'd0 ? DONE : ROUND;
         end
         DONE: if (bus.out_ready) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
      if (abt && fsm != IDLE) begin
         fsm_d = IDLE;
         st_d  = '0;
         cnt_d = '0;
      end
   end
endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// tb_aes128_inv_cipher_iter: directed FIPS-197 vectors, handshake timing and reset/abort behaviour.
// Round keys come from a two-set store indexed by the DUT's rk_idx.
module tb_aes128_inv_cipher_iter;
   logic clk = 1'b0, rst = 1'b1;
`ifdef AES128_INV_CIPHER_ABORT_EN
   logic abort = 1'b0;
`endif
   aes128_inv_cipher_iter_if bus ();
   aes128_inv_cipher_iter dut (
      .clk(clk),
      .rst(rst),
`ifdef AES128_INV_CIPHER_ABORT_EN
      .abort(abort),
`endif
      .bus(bus)
   );
   always #5 clk = ~clk;
   localparam logic [127:0] ct1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] pt1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] ct2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] pt2 = 128'h3243f6a8885a308d313198a2e0370734;
   logic [127:0] keys [2][11] = '{
      '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5},
      '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6}};
   int kset = 0;
   assign bus.rk = bus.rk_idx <= 4'd10 ? keys[kset][bus.rk_idx] : '0;
   int n_chk = 0, n_fail = 0;
   int cyc = 0, acc_last = 0, acc_prev = 0, ov_rise = 0, ov_cnt = 0;
   logic ov_prev = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (bus.in_valid && bus.in_ready && !rst) begin
         acc_prev = acc_last;
         acc_last = cyc;
      end
      if (bus.out_valid && !ov_prev) ov_rise = cyc;
      if (bus.out_valid) ov_cnt++;
      ov_prev = bus.out_valid;
   end
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_out(input int lim, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         step();
         ok = bus.out_valid;
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic ok;
      int   n_ov;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.data_in   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_data_out", bus.data_out, '0);
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("rst_rk_idx", 128'(bus.rk_idx), 128'(10));
      bus.data_in  = ct1;
      bus.in_valid = 1'b1;
      chk("acc_rk_idx", 128'(bus.rk_idx), 128'(10));
      step();
      bus.in_valid = 1'b0;
      bus.data_in  = '1;
      for (int i = 9; i >= 0; i--) begin
         chk("round_rk_idx", 128'(bus.rk_idx), 128'(i));
         chk("round_out_valid", 128'(bus.out_valid), 128'(0));
         step();
      end
      chk("c1_out_valid", 128'(bus.out_valid), 128'(1));
      chk("c1_data_out", bus.data_out, pt1);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("bp_data_out", bus.data_out, pt1);
         chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
         chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
      end
      bus.data_in   = ct1;
      bus.out_ready = 1'b1;
      step();
      chk("rel_in_ready", 128'(bus.in_ready), 128'(1));
      chk("rel_out_valid", 128'(bus.out_valid), 128'(0));
      step();
      bus.data_in = ct2;
      chk("b2b_first_acc", 128'(bus.rk_idx), 128'(9));
      wait_out(15, ok);
      chk("b2b_pt1_valid", 128'(ok), 128'(1));
      chk("b2b_pt1", bus.data_out, pt1);
      kset = 1;
      step();
      chk("b2b_idle", 128'(bus.in_ready), 128'(1));
      step();
      bus.in_valid = 1'b0;
      chk("b2b_second_acc", 128'(bus.in_ready), 128'(0));
      chk("b2b_interval", 128'(acc_last - acc_prev), 128'(12));
      wait_out(15, ok);
      chk("b2b_pt2_valid", 128'(ok), 128'(1));
      chk("b2b_pt2", bus.data_out, pt2);
      step();
      chk("b2b_latency", 128'(ov_rise - acc_last), 128'(11));
      kset         = 0;
      bus.data_in  = ct1;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (4) step();
      chk("mid_rk_idx", 128'(bus.rk_idx), 128'(5));
      n_ov = ov_cnt;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("mid_rst_data_out", bus.data_out, '0);
      chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("mid_rst_rk_idx", 128'(bus.rk_idx), 128'(10));
      step();
      rst = 1'b0;
      repeat (15) step();
      chk("mid_no_valid", 128'(ov_cnt), 128'(n_ov));
      bus.data_in  = ct1;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      wait_out(15, ok);
      chk("post_rst_valid", 128'(ok), 128'(1));
      chk("post_rst_pt1", bus.data_out, pt1);
      step();
`ifdef AES128_INV_CIPHER_ABORT_EN
      kset         = 1;
      bus.data_in  = ct2;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (2) step();
      chk("abort_rk_idx", 128'(bus.rk_idx), 128'(7));
      n_ov  = ov_cnt;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
      chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
      chk("abort_data_out", bus.data_out, '0);
      bus.in_valid = 1'b1;
      abort        = 1'b1;
      step();
      chk("abort_idle_in_ready", 128'(bus.in_ready), 128'(1));
      chk("abort_idle_rk_idx", 128'(bus.rk_idx), 128'(10));
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      repeat (12) step();
      chk("abort_no_valid", 128'(ov_cnt), 128'(n_ov));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
